// File: rtl/uart_rx_deserializer.sv
// UART receiver (8 data bits, even parity, 1 stop) with 16x oversampling and a
// 3-sample majority vote per bit; emits each byte with a one-cycle valid strobe.
module uart_rx_deserializer #(
   parameter int CLK_FREQ   = 48_000_000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       serial_in,
   output logic [7:0] o_data,
   output logic       o_valid,
   output logic       o_parity_err,
   output logic       o_framing_err,
   output logic       o_busy
);

   localparam int TICK_DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
   localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int S_W      = $clog2(OVERSAMPLE);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
   localparam logic [S_W-1:0]   S_A      = S_W'(OVERSAMPLE / 2 - 1);
   localparam logic [S_W-1:0]   S_B      = S_W'(OVERSAMPLE / 2);
   localparam logic [S_W-1:0]   S_C      = S_W'(OVERSAMPLE / 2 + 1);
   localparam logic [S_W-1:0]   S_LAST   = S_W'(OVERSAMPLE - 1);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;
   localparam logic [2:0] ST_BREAK  = 3'd5;

   function automatic logic vote3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   function automatic logic odd_ones(input logic [7:0] d);
      return ^d;
   endfunction

   logic             sync1_q, sync2_q;
   logic [2:0]       state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [S_W-1:0]   s_q, s_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             par_q, par_d;
   logic [1:0]       samp_q, samp_d;
   logic [7:0]       data_q, data_d;
   logic             perr_q, perr_d;
   logic             ferr_q, ferr_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;

   logic rx_s, tick_s, decide_s, bit_end_s, vote_s;

   assign rx_s      = sync2_q;
   assign tick_s    = (div_q == DIV_LAST);
   assign decide_s  = tick_s && (s_q == S_C);
   assign bit_end_s = tick_s && (s_q == S_LAST);
   // Third sample is the live line value on the deciding tick.
   assign vote_s    = vote3(samp_q[0], samp_q[1], rx_s);

   // Next-state logic: counters, sampling, frame FSM and output updates.
   always_comb begin
      state_d   = state_q;
      div_d     = tick_s ? '0 : div_q + DIV_W'(1);
      s_d       = tick_s ? ((s_q == S_LAST) ? '0 : s_q + S_W'(1)) : s_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      par_d     = par_q;
      samp_d    = samp_q;
      data_d    = data_q;
      perr_d    = perr_q;
      ferr_d    = ferr_q;
      valid_d   = 1'b0;

      if (tick_s && (s_q == S_A)) begin
         samp_d[0] = rx_s;
      end else if (tick_s && (s_q == S_B)) begin
         samp_d[1] = rx_s;
      end else begin
         samp_d = samp_q;
      end

      case (state_q)
         ST_IDLE: begin
            div_d = '0;
            s_d   = '0;
            if (!rx_s) begin
               state_d = ST_START;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_START: begin
            if (decide_s && vote_s) begin
               state_d = ST_IDLE;
            end else if (bit_end_s) begin
               state_d   = ST_DATA;
               bit_idx_d = 3'd0;
            end else begin
               state_d = ST_START;
            end
         end
         ST_DATA: begin
            if (decide_s) begin
               shift_d[bit_idx_q] = vote_s;
            end else begin
               shift_d = shift_q;
            end
            if (bit_end_s) begin
               if (bit_idx_q == 3'd7) begin
                  state_d = ST_PARITY;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               state_d = ST_DATA;
            end
         end
         ST_PARITY: begin
            if (decide_s) begin
               par_d = vote_s;
            end else begin
               par_d = par_q;
            end
            if (bit_end_s) begin
               state_d = ST_STOP;
            end else begin
               state_d = ST_PARITY;
            end
         end
         ST_STOP: begin
            // Leave at mid stop bit so a following start edge is never missed.
            if (decide_s) begin
               data_d  = shift_q;
               perr_d  = par_q ^ odd_ones(shift_q);
               ferr_d  = ~vote_s;
               valid_d = 1'b1;
               state_d = vote_s ? ST_IDLE : ST_BREAK;
            end else begin
               state_d = ST_STOP;
            end
         end
         ST_BREAK: begin
            div_d = '0;
            s_d   = '0;
            if (rx_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_BREAK;
            end
         end
         default: begin
            state_d = ST_IDLE;
            div_d   = '0;
            s_d     = '0;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers; synchronizer flops reset to the idle line level.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         state_q   <= ST_IDLE;
         div_q     <= '0;
         s_q       <= '0;
         bit_idx_q <= 3'd0;
         shift_q   <= 8'd0;
         par_q     <= 1'b0;
         samp_q    <= 2'b00;
         data_q    <= 8'd0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         sync1_q   <= serial_in;
         sync2_q   <= sync1_q;
         state_q   <= state_d;
         div_q     <= div_d;
         s_q       <= s_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         samp_q    <= samp_d;
         data_q    <= data_d;
         perr_q    <= perr_d;
         ferr_q    <= ferr_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
      end
   end

   assign o_data        = data_q;
   assign o_valid       = valid_q;
   assign o_parity_err  = perr_q;
   assign o_framing_err = ferr_q;
   assign o_busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: directed frame table, corner-case
// sequences and randomized frames checked against a frame-level reference model.
module tb_uart_rx_deserializer;

   localparam int BAUD     = 9600;
   localparam int OS       = 16;
   localparam int TD       = 8;
   localparam int CLK_FREQ = BAUD * OS * TD;
   localparam int BIT      = OS * TD;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       serial_in;
   logic [7:0] o_data;
   logic       o_valid;
   logic       o_parity_err;
   logic       o_framing_err;
   logic       o_busy;

   always #5 clk = ~clk;

   uart_rx_deserializer #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD      (BAUD),
      .OVERSAMPLE(OS)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .serial_in    (serial_in),
      .o_data       (o_data),
      .o_valid      (o_valid),
      .o_parity_err (o_parity_err),
      .o_framing_err(o_framing_err),
      .o_busy       (o_busy)
   );

   typedef struct packed {
      logic [7:0] d;
      logic       p;
      logic       f;
   } rx_t;

   typedef struct {
      logic [7:0] d;
      logic       par;
      logic       stop;
      logic [7:0] ed;
      logic       ep;
      logic       ef;
   } vec_t;

   int   n_pass  = 0;
   int   n_total = 0;
   int   consec_cnt = 0;
   logic prev_v = 1'b0;
   rx_t  rx_q[$];
   rx_t  exp_q[$];

   // Capture every delivered byte away from the active edge.
   always @(negedge clk) begin
      if (o_valid) begin
         rx_q.push_back({o_data, o_parity_err, o_framing_err});
         if (prev_v) consec_cnt++;
      end
      prev_v = o_valid;
   end

   initial begin
      #(95000 * 10);
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", name, act, exp);
   endtask

   function automatic logic [10:0] mk(input logic [7:0] d, input logic p, input logic s);
      return {s, p, d, 1'b0};
   endfunction

   // Reference: even parity expected, so error is parity bit xor odd ones count.
   function automatic rx_t model(input logic [7:0] d, input logic p, input logic s);
      rx_t r;
      r.d = d;
      r.p = p ^ logic'($countones(d) % 2);
      r.f = ~s;
      return r;
   endfunction

   task automatic send_bits(input logic [10:0] fr, input int nb, input int per);
      for (int i = 0; i < nb; i++) begin
         serial_in = fr[i];
         repeat (per) @(posedge clk);
         #1;
      end
   endtask

   task automatic idle(input int n);
      serial_in = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   vec_t tbl [6];
   rx_t  r;

   initial begin
      tbl[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
      tbl[1] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
      tbl[2] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
      tbl[3] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
      tbl[4] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
      tbl[5] = '{8'h7E, 1'b0, 1'b0, 8'h7E, 1'b0, 1'b1};

      reset_n   = 1'b0;
      serial_in = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_data", o_data, 8'h00);
      check("reset_valid", o_valid, 1'b0);
      check("reset_perr", o_parity_err, 1'b0);
      check("reset_ferr", o_framing_err, 1'b0);
      check("reset_busy", o_busy, 1'b0);
      reset_n = 1'b1;
      idle(20);

      for (int i = 0; i < 6; i++) begin
         rx_q.delete();
         send_bits(mk(tbl[i].d, tbl[i].par, tbl[i].stop), 11, BIT);
         idle(2 * BIT);
         check($sformatf("tbl%0d_count", i), rx_q.size(), 1);
         if (rx_q.size() > 0) r = rx_q.pop_front();
         else r = '0;
         check($sformatf("tbl%0d_data", i), r.d, tbl[i].ed);
         check($sformatf("tbl%0d_perr", i), r.p, tbl[i].ep);
         check($sformatf("tbl%0d_ferr", i), r.f, tbl[i].ef);
         check($sformatf("tbl%0d_busy_after", i), o_busy, 1'b0);
      end

      // Short low glitch: well before the mid-bit samples.
      rx_q.delete();
      serial_in = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("glitch_busy_high", o_busy, 1'b1);
      idle(3 * BIT);
      check("glitch_busy_low", o_busy, 1'b0);
      check("glitch_no_valid", rx_q.size(), 0);

      // Stop bit 0 followed by a long break.
      rx_q.delete();
      send_bits(mk(8'h3C, 1'b0, 1'b0), 10, BIT);
      serial_in = 1'b0;
      repeat (20 * BIT) @(posedge clk);
      #1;
      check("break_count", rx_q.size(), 1);
      if (rx_q.size() > 0) r = rx_q[0];
      else r = '0;
      check("break_data", r.d, 8'h3C);
      check("break_perr", r.p, 1'b0);
      check("break_ferr", r.f, 1'b1);
      check("break_busy_held", o_busy, 1'b1);
      idle(2 * BIT);
      check("break_busy_released", o_busy, 1'b0);
      check("break_single_valid", rx_q.size(), 1);

      // Back-to-back frames, transmitter about 2% fast.
      rx_q.delete();
      send_bits(mk(8'h55, 1'b0, 1'b1), 11, BIT - 3);
      send_bits(mk(8'hAA, 1'b0, 1'b1), 11, BIT - 3);
      idle(2 * BIT);
      check("b2b_count", rx_q.size(), 2);
      if (rx_q.size() > 1) begin
         check("b2b_data0", rx_q[0].d, 8'h55);
         check("b2b_errs0", {rx_q[0].p, rx_q[0].f}, 2'b00);
         check("b2b_data1", rx_q[1].d, 8'hAA);
         check("b2b_errs1", {rx_q[1].p, rx_q[1].f}, 2'b00);
      end

      // Reset in the middle of the data bits aborts the frame.
      rx_q.delete();
      send_bits(mk(8'h77, 1'b0, 1'b1), 5, BIT);
      reset_n   = 1'b0;
      serial_in = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("midrst_data", o_data, 8'h00);
      check("midrst_valid", o_valid, 1'b0);
      check("midrst_busy", o_busy, 1'b0);
      check("midrst_errs", {o_parity_err, o_framing_err}, 2'b00);
      reset_n = 1'b1;
      idle(12 * BIT);
      check("midrst_no_valid", rx_q.size(), 0);
      send_bits(mk(8'h88, 1'b0, 1'b1), 11, BIT);
      idle(2 * BIT);
      check("after_rst_count", rx_q.size(), 1);
      if (rx_q.size() > 0) r = rx_q.pop_front();
      else r = '0;
      check("after_rst_data", r.d, 8'h88);
      check("after_rst_errs", {r.p, r.f}, 2'b00);

      // Randomized frames against the frame-level model.
      rx_q.delete();
      exp_q.delete();
      for (int i = 0; i < 20; i++) begin
         logic [7:0] d;
         logic       p, s;
         int         per, gap;
         d   = 8'($urandom);
         p   = logic'($countones(d) % 2);
         if ($urandom_range(0, 3) == 0) p = ~p;
         s   = ($urandom_range(0, 5) != 0);
         per = $urandom_range(BIT - 2, BIT + 2);
         gap = s ? $urandom_range(0, 2) : $urandom_range(1, 2);
         exp_q.push_back(model(d, p, s));
         send_bits(mk(d, p, s), 11, per);
         if (gap > 0) idle(gap * per);
      end
      idle(2 * BIT);
      check("rand_count", rx_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         check($sformatf("rand%0d_data", i), rx_q[i].d, exp_q[i].d);
         check($sformatf("rand%0d_perr", i), rx_q[i].p, exp_q[i].p);
         check($sformatf("rand%0d_ferr", i), rx_q[i].f, exp_q[i].f);
      end

      check("valid_never_consecutive", consec_cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
